// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared definitions: FSM encoding, owner codes,
// default parameters and a counter-width helper.
package mem_arb_pkg;

    localparam int AW_DEF         = 16;
    localparam int DW_DEF         = 16;
    localparam int RD_LAT_DEF     = 1;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    function automatic int cnt_w(input int max_v);
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU path, the DMA engine, the RAM
// macro and the arbiter; slave is the arbiter side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata,
        input  busy, owner
    );

endinterface

// File: rtl/mem_arbiter_starve.sv
// Saturating count of edges a pending DMA request was passed
// over; o_force tells the arbiter to grant DMA next.
module mem_arb_starve
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dma_req,
    input  logic i_dma_grant,
    output logic o_force
);

    localparam int SW = cnt_w(STARVE_MAX);
    localparam logic [SW-1:0] CNT_MAX = SW'(STARVE_MAX);

    logic [SW-1:0] r_cnt;

    // count passed-over edges, clear on grant or no request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_dma_req || i_dma_grant) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single synchronous RAM port:
// CPU has priority, DMA is forced after a bounded wait.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] ISSUE = 2'(ST_ISSUE);
    localparam logic [1:0] WAIT  = 2'(ST_WAIT);
    localparam logic [1:0] DONE  = 2'(ST_DONE);

    localparam int LW = cnt_w(RD_LAT);
    localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(1);
    localparam bit LAT1 = (RD_LAT == 1);

    logic [1:0]    r_state;
    logic          r_owner;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          r_ram_we;
    logic [LW-1:0] r_lat;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;

    logic w_idle;
    logic w_force;
    logic w_grant_cpu;
    logic w_grant_dma;
    logic w_capture;

    assign w_idle = (r_state == IDLE);

    assign w_grant_dma = w_idle && bus.dma_req
                      && (w_force || !bus.cpu_req);

    assign w_grant_cpu = w_idle && bus.cpu_req
                      && !(bus.dma_req && w_force);

    // read data is on ram_rdata on the last latency edge
    assign w_capture = (r_state == ISSUE && !r_ram_we && LAT1)
                    || (r_state == WAIT && r_lat == LAT_LAST);

    mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .i_dma_req   (bus.dma_req),
        .i_dma_grant (w_grant_dma),
        .o_force     (w_force)
    );

    // access sequencer: grant, issue, wait for data, acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_lat       <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_dma) begin
                        r_ram_addr  <= bus.dma_addr;
                        r_ram_wdata <= bus.dma_wdata;
                        r_ram_we    <= bus.dma_we;
                        r_owner     <= OWN_DMA;
                        r_state     <= ISSUE;
                    end else if (w_grant_cpu) begin
                        r_ram_addr  <= bus.cpu_addr;
                        r_ram_wdata <= bus.cpu_wdata;
                        r_ram_we    <= bus.cpu_we;
                        r_owner     <= OWN_CPU;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_ram_we <= 1'b0;
                    if (r_ram_we || LAT1) begin
                        r_state <= DONE;
                    end else begin
                        r_lat   <= LAT_INIT;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // steer captured read data to the owner; the other holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else if (w_capture) begin
            if (r_owner == OWN_DMA) begin
                r_dma_rdata <= bus.ram_rdata;
            end else begin
                r_cpu_rdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.ram_we    = r_ram_we;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dma_rdata = r_dma_rdata;
    assign bus.cpu_ack   = (r_state == DONE) && (r_owner == OWN_CPU);
    assign bus.dma_ack   = (r_state == DONE) && (r_owner == OWN_DMA);
    assign bus.busy      = (r_state != IDLE);
    assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();
    mem_arbiter_if #(.AW(16), .DW(16)) bus3 ();

    mem_arbiter #(
        .AW(16), .DW(16), .RD_LAT(1), .STARVE_MAX(SMAX)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(
        .AW(16), .DW(16), .RD_LAT(3), .STARVE_MAX(SMAX)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    // RAM models: latency 1 (address register only) and 3
    logic [15:0] mem  [256];
    logic [15:0] mem3 [256];
    logic [15:0] p1, p2;

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = mem[bus.ram_addr[7:0]];

    always @(posedge clk) begin
        if (bus3.ram_we) mem3[bus3.ram_addr[7:0]] <= bus3.ram_wdata;
        p1 <= mem3[bus3.ram_addr[7:0]];
        p2 <= p1;
    end
    assign bus3.ram_rdata = p2;

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0;
        bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0;
        bus.dma_addr = 0; bus.dma_wdata = 0;
        bus3.cpu_req = 0; bus3.cpu_we = 0;
        bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
        bus3.dma_req = 0; bus3.dma_we = 0;
        bus3.dma_addr = 0; bus3.dma_wdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #1;
        n_tests++;
        if ({bus.busy, bus.owner, bus.ram_we, bus.cpu_ack, bus.dma_ack}
            !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl: got busy/own/we/cack/dack=%b want 00000",
                     {bus.busy, bus.owner, bus.ram_we, bus.cpu_ack, bus.dma_ack});
        end
        n_tests++;
        if ({bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dma_rdata}
            !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_data: got addr=%h wd=%h crd=%h drd=%h want 0",
                     bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dma_rdata);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_cpu_write();
        bus.cpu_req = 1; bus.cpu_we = 1;
        bus.cpu_addr = 16'h0042; bus.cpu_wdata = 16'hBEEF;
        @(negedge clk);
        n_tests++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h0042
            || bus.ram_wdata !== 16'hBEEF || bus.cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_issue: got we=%b addr=%h wd=%h ack=%b want 1 0042 beef 0",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_ack);
        end
        @(negedge clk);
        n_tests++;
        if (bus.ram_we !== 1'b0 || bus.cpu_ack !== 1'b1
            || bus.dma_ack !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_done: got we=%b cack=%b dack=%b busy=%b want 0 1 0 1",
                     bus.ram_we, bus.cpu_ack, bus.dma_ack, bus.busy);
        end
        bus.cpu_req = 0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_idle: got busy=%b ack=%b want 0 0",
                     bus.busy, bus.cpu_ack);
        end
    endtask

    task automatic test_cpu_read();
        bus.cpu_req = 1; bus.cpu_we = 0;
        bus.cpu_addr = 16'h0042; bus.cpu_wdata = 16'h0000;
        @(negedge clk);
        n_tests++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0042
            || bus.cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_issue: got we=%b addr=%h ack=%b want 0 0042 0",
                     bus.ram_we, bus.ram_addr, bus.cpu_ack);
        end
        @(negedge clk);
        n_tests++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rd_lat1: got ack=%b data=%h want 1 beef",
                     bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 0;
        @(negedge clk);
        // same access on the RD_LAT=3 instance
        bus3.cpu_req = 1; bus3.cpu_we = 1;
        bus3.cpu_addr = 16'h0042; bus3.cpu_wdata = 16'hBEEF;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus3.cpu_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_lat3: got ack=%b want 1", bus3.cpu_ack);
        end
        bus3.cpu_req = 0;
        @(negedge clk);
        bus3.cpu_req = 1; bus3.cpu_we = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus3.cpu_ack !== (i == 3)) begin
                n_fail++;
                $display("FAIL rd_lat3_ack cyc%0d: got %b want %b",
                         i + 1, bus3.cpu_ack, (i == 3));
            end
        end
        n_tests++;
        if (bus3.cpu_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rd_lat3_data: got %h want beef", bus3.cpu_rdata);
        end
        bus3.cpu_req = 0;
        @(negedge clk);
        n_tests++;
        if (bus3.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_lat3_idle: got busy=%b want 0", bus3.busy);
        end
    endtask

    task automatic test_simultaneous();
        bus.cpu_req = 1; bus.cpu_we = 1;
        bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'h1111;
        bus.dma_req = 1; bus.dma_we = 1;
        bus.dma_addr = 16'h0020; bus.dma_wdata = 16'h2222;
        @(negedge clk);
        n_tests++;
        if (bus.owner !== 1'b0 || bus.ram_addr !== 16'h0010) begin
            n_fail++;
            $display("FAIL sim_first: got owner=%b addr=%h want 0 0010",
                     bus.owner, bus.ram_addr);
        end
        @(negedge clk);
        n_tests++;
        if (bus.cpu_ack !== 1'b1 || bus.dma_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_cack: got cack=%b dack=%b want 1 0",
                     bus.cpu_ack, bus.dma_ack);
        end
        bus.cpu_req = 0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.owner !== 1'b1 || bus.ram_addr !== 16'h0020
            || bus.ram_wdata !== 16'h2222 || bus.ram_we !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_second: got owner=%b addr=%h wd=%h we=%b want 1 0020 2222 1",
                     bus.owner, bus.ram_addr, bus.ram_wdata, bus.ram_we);
        end
        @(negedge clk);
        n_tests++;
        if (bus.dma_ack !== 1'b1 || bus.cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_dack: got dack=%b cack=%b want 1 0",
                     bus.dma_ack, bus.cpu_ack);
        end
        bus.dma_req = 0;
        @(negedge clk);
        n_tests++;
        if (mem[8'h10] !== 16'h1111 || mem[8'h20] !== 16'h2222) begin
            n_fail++;
            $display("FAIL sim_ram: got %h %h want 1111 2222",
                     mem[8'h10], mem[8'h20]);
        end
    endtask

    task automatic test_starve();
        logic [4:0] pat;
        pat = 5'b10100;
        bus.cpu_req = 1; bus.cpu_we = 1;
        bus.cpu_addr = 16'h0001; bus.cpu_wdata = 16'hAAAA;
        bus.dma_req = 1; bus.dma_we = 1;
        bus.dma_addr = 16'h0002; bus.dma_wdata = 16'h5555;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                n_tests++;
                if (bus.ram_we !== 1'b1 || bus.owner !== pat[k / 3]) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d: got we=%b owner=%b want 1 %b",
                             k / 3, bus.ram_we, bus.owner, pat[k / 3]);
                end
            end
        end
        bus.cpu_req = 0;
        bus.dma_req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus.dma_req = 1; bus.dma_we = 1;
        bus.dma_addr = 16'h0030; bus.dma_wdata = 16'h3333;
        @(negedge clk);
        n_tests++;
        if (bus.ram_we !== 1'b1 || bus.busy !== 1'b1 || bus.owner !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_issue: got we=%b busy=%b owner=%b want 1 1 1",
                     bus.ram_we, bus.busy, bus.owner);
        end
        rst = 1;
        #1;
        n_tests++;
        if (bus.ram_we !== 1'b0 || bus.busy !== 1'b0
            || bus.dma_ack !== 1'b0 || bus.owner !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async: got we=%b busy=%b dack=%b owner=%b want 0",
                     bus.ram_we, bus.busy, bus.dma_ack, bus.owner);
        end
        bus.dma_req = 0;
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.dma_ack !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_noack%0d: got dack=%b busy=%b want 0 0",
                         k, bus.dma_ack, bus.busy);
            end
        end
        n_tests++;
        if (mem[8'h30] !== 16'h0000) begin
            n_fail++;
            $display("FAIL rmid_ram: got %h want 0000", mem[8'h30]);
        end
    endtask

    task automatic test_back_to_back();
        bus.dma_req = 1; bus.dma_we = 1;
        bus.dma_addr = 16'h0040; bus.dma_wdata = 16'h4444;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.dma_ack !== (k == 1 || k == 4)
                || bus.ram_we !== (k == 0 || k == 3)) begin
                n_fail++;
                $display("FAIL b2b_cyc%0d: got dack=%b we=%b want %b %b",
                         k, bus.dma_ack, bus.ram_we,
                         (k == 1 || k == 4), (k == 0 || k == 3));
            end
        end
        bus.dma_req = 0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    // reference model state: one access record plus expectations
    int          n, m_g, m_lat, m_starve;
    bit          m_act, m_we, m_own, g_cpu, g_dma, c_pend, d_pend;
    logic [15:0] m_rd, e_addr, e_wd, e_crd, e_drd;
    logic [15:0] shadow [256];
    logic [4:0]  exp_ctl, got_ctl;
    bit          busy_e, cack_e, dack_e, we_e;

    task automatic test_random();
        do_reset();
        n = 0; m_act = 0; m_starve = 0; m_own = 0; m_we = 0;
        m_g = 0; m_lat = 0; m_rd = 0;
        e_addr = 0; e_wd = 0; e_crd = 0; e_drd = 0;
        c_pend = 0; d_pend = 0;
        for (int i = 0; i < 256; i++) shadow[i] = 16'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!c_pend) begin
                bus.cpu_req = 0;
                if ($urandom_range(0, 3) != 0) begin
                    c_pend = 1;
                    bus.cpu_req = 1;
                    bus.cpu_we = 1'($urandom_range(0, 1));
                    bus.cpu_addr = 16'(8'h80 + $urandom_range(0, 15));
                    bus.cpu_wdata = 16'($urandom);
                end
            end
            if (!d_pend) begin
                bus.dma_req = 0;
                if ($urandom_range(0, 1) != 0) begin
                    d_pend = 1;
                    bus.dma_req = 1;
                    bus.dma_we = 1'($urandom_range(0, 1));
                    bus.dma_addr = 16'(8'h80 + $urandom_range(0, 15));
                    bus.dma_wdata = 16'($urandom);
                end
            end
            @(posedge clk);
            n++;
            if (m_act && !m_we && n == m_g + m_lat) begin
                if (m_own) e_drd = m_rd;
                else e_crd = m_rd;
            end
            g_cpu = 0; g_dma = 0;
            if (!m_act || n >= m_g + m_lat + 2) begin
                m_act = 0;
                if (bus.dma_req && m_starve == SMAX) g_dma = 1;
                else if (bus.cpu_req) g_cpu = 1;
                else if (bus.dma_req) g_dma = 1;
                if (g_cpu || g_dma) begin
                    m_act = 1; m_g = n; m_own = g_dma;
                    m_we = g_dma ? bus.dma_we : bus.cpu_we;
                    e_addr = g_dma ? bus.dma_addr : bus.cpu_addr;
                    e_wd = g_dma ? bus.dma_wdata : bus.cpu_wdata;
                    m_lat = 1;
                    if (m_we) shadow[e_addr[7:0]] = e_wd;
                    m_rd = shadow[e_addr[7:0]];
                end
            end
            if (bus.dma_req && !g_dma)
                m_starve = (m_starve >= SMAX) ? SMAX : m_starve + 1;
            else
                m_starve = 0;
            @(negedge clk);
            busy_e = m_act && n <= m_g + m_lat;
            cack_e = m_act && n == m_g + m_lat && !m_own;
            dack_e = m_act && n == m_g + m_lat && m_own;
            we_e = m_act && m_we && n == m_g;
            exp_ctl = {busy_e, cack_e, dack_e, we_e, m_own};
            got_ctl = {bus.busy, bus.cpu_ack, bus.dma_ack,
                       bus.ram_we, bus.owner};
            n_tests++;
            if (got_ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL rnd_ctl edge%0d: got busy/cack/dack/we/own=%b want %b",
                         n, got_ctl, exp_ctl);
            end
            n_tests++;
            if (bus.ram_addr !== e_addr || bus.ram_wdata !== e_wd) begin
                n_fail++;
                $display("FAIL rnd_ram edge%0d: got addr=%h wd=%h want %h %h",
                         n, bus.ram_addr, bus.ram_wdata, e_addr, e_wd);
            end
            n_tests++;
            if (bus.cpu_rdata !== e_crd || bus.dma_rdata !== e_drd) begin
                n_fail++;
                $display("FAIL rnd_rdata edge%0d: got crd=%h drd=%h want %h %h",
                         n, bus.cpu_rdata, bus.dma_rdata, e_crd, e_drd);
            end
            if (cack_e) c_pend = 0;
            if (dack_e) d_pend = 0;
        end
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0;
            mem3[i] = 16'h0;
        end
        do_reset();
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_simultaneous();
        test_starve();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
